// File: rtl/ucounter_pkg.sv
// ---------------------------------------------------------------------------
// ucounter_pkg
// Shared definitions for the parametrised up/down counter ucounter_param.
//   uc_dir_e   : count direction encoding of _updown  (UC_UP=1, UC_DOWN=0)
//   uc_mode_e  : bound behaviour encoding of _wrapstop (UC_WRAP=1, UC_STOP=0)
//   uc_addsub  : wide add/subtract used for all bound arithmetic; callers
//                size the result back to WIDTH+1 bits.
// ---------------------------------------------------------------------------
package ucounter_pkg;

    // Widest counter supported by the shared arithmetic helper.
    localparam int unsigned UC_MAX_W = 64;

    typedef enum logic {
        UC_DOWN = 1'b0,
        UC_UP   = 1'b1
    } uc_dir_e;

    typedef enum logic {
        UC_STOP = 1'b0,
        UC_WRAP = 1'b1
    } uc_mode_e;

    typedef logic [UC_MAX_W:0] uc_wide_t;

    // a + b when sub=0, a - b when sub=1 (modulo 2**(UC_MAX_W+1)).
    function automatic uc_wide_t uc_addsub(input uc_wide_t a, input uc_wide_t b, input logic sub);
        uc_wide_t r;
        if (sub) begin
            r = a - b;
        end else begin
            r = a + b;
        end
        return r;
    endfunction

endpackage

// File: rtl/ucounter_param_if.sv
// ---------------------------------------------------------------------------
// ucounter_param_if
// Control/data bundle of ucounter_param. The counter binds to the slave
// modport; the controlling block (or a testbench) binds to master.
//   _set, _load, preld_val, lim_val, _updown, _wrapstop, _carry_in : controls
//   dcount, overflow, underflow : registered results
//   carry_out                   : combinational cascade output
// ---------------------------------------------------------------------------
interface ucounter_param_if #(
    parameter int unsigned WIDTH = 16
);
    logic             _set;
    logic             _load;
    logic [WIDTH-1:0] preld_val;
    logic [WIDTH-1:0] lim_val;
    logic             _updown;
    logic             _wrapstop;
    logic             _carry_in;
    logic [WIDTH-1:0] dcount;
    logic             overflow;
    logic             underflow;
    logic             carry_out;

    modport master (
        output _set, _load, preld_val, lim_val, _updown, _wrapstop, _carry_in,
        input  dcount, overflow, underflow, carry_out
    );

    modport slave (
        input  _set, _load, preld_val, lim_val, _updown, _wrapstop, _carry_in,
        output dcount, overflow, underflow, carry_out
    );
endinterface

// File: rtl/ucounter_next.sv
// ---------------------------------------------------------------------------
// ucounter_next
// Combinational next-count logic for ucounter_param. All bound arithmetic is
// done in WIDTH+1 bits so that lim_val = all-ones gives a modulo 2**WIDTH
// counter without losing the carry.
// Ports:
//   dcount     in  WIDTH  current count
//   lim_val    in  WIDTH  upper bound (range 0..lim_val)
//   _updown    in  1      1 = up, 0 = down
//   _wrapstop  in  1      1 = wrap at bound, 0 = saturate at bound
//   _carry_in  in  1      count enable (only used for carry_out)
//   next_val   out WIDTH  count after one enabled step
//   ovf_evt    out 1      an up step would cross the upper bound
//   unf_evt    out 1      a down step would cross zero
//   carry_out  out 1      _carry_in & crossing in the current direction
// ---------------------------------------------------------------------------
module ucounter_next
    import ucounter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0] dcount,
    input  logic [WIDTH-1:0] lim_val,
    input  logic             _updown,
    input  logic             _wrapstop,
    input  logic             _carry_in,
    output logic [WIDTH-1:0] next_val,
    output logic             ovf_evt,
    output logic             unf_evt,
    output logic             carry_out
);

    typedef logic [WIDTH:0] ext_t;

    localparam ext_t STEP_X = ext_t'(STEP);
    localparam ext_t ONE_X  = ext_t'(1'b1);

    // WIDTH+1-bit add/subtract built on the shared wide helper.
    function automatic ext_t ext_addsub(input ext_t a, input ext_t b, input logic sub);
        return ext_t'(uc_addsub(uc_wide_t'(a), uc_wide_t'(b), sub));
    endfunction

    ext_t cnt_x_s;
    ext_t lim_x_s;
    ext_t lim1_x_s;
    ext_t up_sum_s;
    ext_t up_wrap_s;
    ext_t dn_diff_s;
    ext_t dn_wrap_s;
    ext_t next_x_s;
    logic cross_up_s;
    logic cross_dn_s;
    logic dir_up_s;

    assign cnt_x_s   = ext_t'(dcount);
    assign lim_x_s   = ext_t'(lim_val);
    assign lim1_x_s  = ext_addsub(lim_x_s, ONE_X, 1'b0);
    assign up_sum_s  = ext_addsub(cnt_x_s, STEP_X, 1'b0);
    assign up_wrap_s = ext_addsub(up_sum_s, lim1_x_s, 1'b1);
    assign dn_diff_s = ext_addsub(cnt_x_s, STEP_X, 1'b1);
    // A negative wrap result becomes a huge WIDTH+1-bit value, which the
    // range check below then treats as out of range.
    assign dn_wrap_s = ext_addsub(ext_addsub(cnt_x_s, lim1_x_s, 1'b0), STEP_X, 1'b1);

    // A count already above a lowered lim_val also counts as an up-cross.
    assign cross_up_s = (up_sum_s > lim_x_s);
    assign cross_dn_s = (cnt_x_s < STEP_X);
    assign dir_up_s   = (_updown == UC_UP);

    // Next-value selection by direction, crossing and wrap/stop mode.
    always_comb begin
        next_x_s = cnt_x_s;
        if (dir_up_s) begin
            if (!cross_up_s) begin
                next_x_s = up_sum_s;
            end else if (_wrapstop == UC_WRAP) begin
                // STEP larger than the range can leave the wrap outside it.
                if (up_wrap_s > lim_x_s) begin
                    next_x_s = ext_t'(1'b0);
                end else begin
                    next_x_s = up_wrap_s;
                end
            end else begin
                next_x_s = lim_x_s;
            end
        end else begin
            if (!cross_dn_s) begin
                next_x_s = dn_diff_s;
            end else if (_wrapstop == UC_WRAP) begin
                if (dn_wrap_s > lim_x_s) begin
                    next_x_s = lim_x_s;
                end else begin
                    next_x_s = dn_wrap_s;
                end
            end else begin
                next_x_s = ext_t'(1'b0);
            end
        end
    end

    // Every selected value fits in WIDTH bits; the extra bit is always zero.
    assign next_val  = WIDTH'(next_x_s);
    assign ovf_evt   = dir_up_s & cross_up_s;
    assign unf_evt   = (~dir_up_s) & cross_dn_s;
    assign carry_out = _carry_in & (ovf_evt | unf_evt);

endmodule

// File: rtl/ucounter_param.sv
// ---------------------------------------------------------------------------
// ucounter_param
// Parametrised up/down counter/timer primitive with programmable width, step
// and upper bound (modulo lim_val+1), wrap or saturate at the bounds,
// registered overflow/underflow event flags and a combinational carry_out
// for cascading.
// Parameters: WIDTH (count width), STEP (1..2**WIDTH-1), RST_VAL.
// Ports:
//   clk     in  1  clock, all state changes on the rising edge
//   _reset  in  1  synchronous active-high reset
//   bus     ucounter_param_if.slave : controls, dcount, overflow, underflow,
//                                     carry_out
// Priority per edge: _reset > _set > _load > count (_carry_in) > hold.
// Build option: UCOUNTER_STICKY_EN makes overflow/underflow sticky until
// _reset, _set or _load.
// ---------------------------------------------------------------------------
module ucounter_param
    import ucounter_pkg::*;
#(
    parameter int unsigned      WIDTH   = 16,
    parameter int unsigned      STEP    = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input logic             clk,
    input logic             _reset,
    ucounter_param_if.slave bus
);

    logic [WIDTH-1:0] dcount_r;
    logic             overflow_r;
    logic             underflow_r;
    logic [WIDTH-1:0] next_val_s;
    logic [WIDTH-1:0] load_val_s;
    logic             ovf_evt_s;
    logic             unf_evt_s;
    logic             carry_out_s;
    logic             ovf_next_s;
    logic             unf_next_s;

    ucounter_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .dcount    (dcount_r),
        .lim_val   (bus.lim_val),
        ._updown   (bus._updown),
        ._wrapstop (bus._wrapstop),
        ._carry_in (bus._carry_in),
        .next_val  (next_val_s),
        .ovf_evt   (ovf_evt_s),
        .unf_evt   (unf_evt_s),
        .carry_out (carry_out_s)
    );

    // Preload clamped into the legal range 0..lim_val.
    always_comb begin
        load_val_s = bus.preld_val;
        if (bus.preld_val > bus.lim_val) begin
            load_val_s = bus.lim_val;
        end else begin
            load_val_s = bus.preld_val;
        end
    end

    // Flag values after an enabled count step.
    always_comb begin
`ifdef UCOUNTER_STICKY_EN
        ovf_next_s = overflow_r | ovf_evt_s;
        unf_next_s = underflow_r | unf_evt_s;
`else
        ovf_next_s = ovf_evt_s;
        unf_next_s = unf_evt_s;
`endif
    end

    // Count and flag registers with the reset/set/load/count/hold priority.
    always_ff @(posedge clk) begin
        if (_reset) begin
            dcount_r    <= RST_VAL;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus._set) begin
            dcount_r    <= bus.lim_val;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus._load) begin
            dcount_r    <= load_val_s;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus._carry_in) begin
            dcount_r    <= next_val_s;
            overflow_r  <= ovf_next_s;
            underflow_r <= unf_next_s;
        end else begin
            dcount_r    <= dcount_r;
            overflow_r  <= overflow_r;
            underflow_r <= underflow_r;
        end
    end

    assign bus.dcount    = dcount_r;
    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
    assign bus.carry_out = carry_out_s;

endmodule

// File: tb/tb_ucounter_param.sv
// ---------------------------------------------------------------------------
// tb_ucounter_param
// Two 16-bit counters (STEP=1 and STEP=3) share one set of controls. Each is
// tracked by an integer reference model of the counting rules; directed
// scenarios check known values, a random phase checks against the models.
// ---------------------------------------------------------------------------
module tb_ucounter_param;

`ifdef UCOUNTER_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set_i = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] preld = 16'h0000;
    logic [15:0] lim = 16'hFFFF;
    logic        updown = 1'b1;
    logic        wrapstop = 1'b1;
    logic        cin = 1'b0;

    int checks = 0;
    int passed = 0;

    logic [15:0] m1_cnt = 16'h0000;
    logic        m1_ov = 1'b0;
    logic        m1_un = 1'b0;
    logic [15:0] m3_cnt = 16'h0000;
    logic        m3_ov = 1'b0;
    logic        m3_un = 1'b0;

    ucounter_param_if #(.WIDTH(16)) if1 ();
    ucounter_param_if #(.WIDTH(16)) if3 ();

    assign if1._set = set_i;      assign if3._set = set_i;
    assign if1._load = load_i;    assign if3._load = load_i;
    assign if1.preld_val = preld; assign if3.preld_val = preld;
    assign if1.lim_val = lim;     assign if3.lim_val = lim;
    assign if1._updown = updown;  assign if3._updown = updown;
    assign if1._wrapstop = wrapstop; assign if3._wrapstop = wrapstop;
    assign if1._carry_in = cin;   assign if3._carry_in = cin;

    ucounter_param #(.WIDTH(16), .STEP(1), .RST_VAL(16'h0000)) dut1 (
        .clk(clk), ._reset(rst), .bus(if1)
    );
    ucounter_param #(.WIDTH(16), .STEP(3), .RST_VAL(16'h0000)) dut3 (
        .clk(clk), ._reset(rst), .bus(if3)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

    // Reference: state after one edge, returned as {underflow, overflow, count}.
    function automatic logic [17:0] ref_next(input int step, input logic [15:0] cnt,
                                             input logic ov, input logic un);
        longint c, l, s, n;
        logic o, u;
        c = longint'(cnt); l = longint'(lim); s = longint'(step); o = ov; u = un;
        if (rst) begin
            c = 0; o = 1'b0; u = 1'b0;
        end else if (set_i) begin
            c = l; o = 1'b0; u = 1'b0;
        end else if (load_i) begin
            c = (longint'(preld) > l) ? l : longint'(preld); o = 1'b0; u = 1'b0;
        end else if (cin) begin
            if (updown) begin
                if (c + s <= l) begin
                    c = c + s;
                    if (!STICKY) begin o = 1'b0; u = 1'b0; end
                end else begin
                    n = wrapstop ? (c + s - (l + 1)) : l;
                    if (n > l) n = 0;
                    c = n; o = 1'b1;
                    if (!STICKY) u = 1'b0;
                end
            end else begin
                if (c >= s) begin
                    c = c - s;
                    if (!STICKY) begin o = 1'b0; u = 1'b0; end
                end else begin
                    n = wrapstop ? (c + (l + 1) - s) : 0;
                    if (n < 0 || n > l) n = l;
                    c = n; u = 1'b1;
                    if (!STICKY) o = 1'b0;
                end
            end
        end
        return {u, o, 16'(c)};
    endfunction

    function automatic logic ref_carry(input int step, input logic [15:0] cnt);
        longint c, l, s;
        c = longint'(cnt); l = longint'(lim); s = longint'(step);
        return cin && (updown ? (c + s > l) : (c < s));
    endfunction

    // Advance one clock edge and the two models with it; returns #1 after the edge.
    task automatic tick();
        logic [17:0] r1, r3;
        r1 = ref_next(1, m1_cnt, m1_ov, m1_un);
        r3 = ref_next(3, m3_cnt, m3_ov, m3_un);
        @(posedge clk);
        {m1_un, m1_ov, m1_cnt} = r1;
        {m3_un, m3_ov, m3_cnt} = r3;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_i = 1'b0; load_i = 1'b0; cin = 1'b0;
        tick();
        checks++;
        if ({if1.dcount, if1.overflow, if1.underflow} !== {16'h0000, 1'b0, 1'b0})
            $display("FAIL reset_first_s1: got %h/%b/%b want 0000/0/0", if1.dcount, if1.overflow, if1.underflow);
        else passed++;
        checks++;
        if ({if3.dcount, if3.overflow, if3.underflow} !== {16'h0000, 1'b0, 1'b0})
            $display("FAIL reset_first_s3: got %h/%b/%b want 0000/0/0", if3.dcount, if3.overflow, if3.underflow);
        else passed++;
        // Build up some state including a raised flag, then reset over everything.
        rst = 1'b0; lim = 16'h0005; preld = 16'h0004; load_i = 1'b1;
        tick();
        load_i = 1'b0; cin = 1'b1; updown = 1'b1; wrapstop = 1'b0;
        repeat (3) tick();
        rst = 1'b1; set_i = 1'b1; load_i = 1'b1;
        tick();
        checks++;
        if ({if1.dcount, if1.overflow, if1.underflow} !== {16'h0000, 1'b0, 1'b0})
            $display("FAIL reset_busy_s1: got %h/%b/%b want 0000/0/0", if1.dcount, if1.overflow, if1.underflow);
        else passed++;
        rst = 1'b0; set_i = 1'b0; load_i = 1'b0; cin = 1'b0;
    endtask

    task automatic test_up_down();
        lim = 16'hFFFF; wrapstop = 1'b1; preld = 16'h00FC; load_i = 1'b1; cin = 1'b0;
        tick();
        load_i = 1'b0; cin = 1'b1; updown = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if ({if1.dcount, if1.overflow, if1.underflow} !== {16'h00FC + 16'(i), 1'b0, 1'b0})
                $display("FAIL up_step%0d: got %h/%b/%b want %h/0/0", i, if1.dcount, if1.overflow, if1.underflow, 16'h00FC + 16'(i));
            else passed++;
        end
        updown = 1'b0;
        repeat (5) tick();
        checks++;
        if ({if1.dcount, if1.overflow, if1.underflow} !== {16'h00FC, 1'b0, 1'b0})
            $display("FAIL down_back: got %h/%b/%b want 00fc/0/0", if1.dcount, if1.overflow, if1.underflow);
        else passed++;
        checks++;
        if (if3.dcount !== m3_cnt)
            $display("FAIL up_down_s3: got %h want %h", if3.dcount, m3_cnt);
        else passed++;
    endtask

    task automatic test_wrap_overflow();
        lim = 16'h00FF; wrapstop = 1'b1; cin = 1'b0; set_i = 1'b1;
        tick();
        set_i = 1'b0; cin = 1'b1; updown = 1'b1;
        #1;
        checks++;
        if ({if1.dcount, if1.carry_out} !== {16'h00FF, 1'b1})
            $display("FAIL set_carry: got %h/%b want 00ff/1", if1.dcount, if1.carry_out);
        else passed++;
        tick();
        checks++;
        if ({if1.dcount, if1.overflow, if1.underflow} !== {16'h0000, 1'b1, 1'b0})
            $display("FAIL wrap_ovf: got %h/%b/%b want 0000/1/0", if1.dcount, if1.overflow, if1.underflow);
        else passed++;
        checks++;
        if (if1.carry_out !== 1'b0)
            $display("FAIL carry_after_wrap: got %b want 0", if1.carry_out);
        else passed++;
        tick();
        checks++;
        if ({if1.dcount, if1.overflow} !== {16'h0001, STICKY})
            $display("FAIL ovf_pulse: got %h/%b want 0001/%b", if1.dcount, if1.overflow, STICKY);
        else passed++;
    endtask

    task automatic test_stop_saturate();
        lim = 16'h0009; wrapstop = 1'b0; preld = 16'h0008; load_i = 1'b1; cin = 1'b0;
        tick();
        load_i = 1'b0; cin = 1'b1; updown = 1'b1;
        #1;
        checks++;
        if (if3.carry_out !== 1'b1)
            $display("FAIL stop_carry: got %b want 1", if3.carry_out);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({if3.dcount, if3.overflow, if3.underflow} !== {16'h0009, 1'b1, 1'b0})
                $display("FAIL stop_hold%0d: got %h/%b/%b want 0009/1/0", i, if3.dcount, if3.overflow, if3.underflow);
            else passed++;
        end
    endtask

    task automatic test_down_wrap();
        lim = 16'h0009; wrapstop = 1'b1; preld = 16'h0001; load_i = 1'b1; cin = 1'b0;
        tick();
        load_i = 1'b0; cin = 1'b1; updown = 1'b0;
        tick();
        checks++;
        if ({if3.dcount, if3.overflow, if3.underflow} !== {16'h0008, 1'b0, 1'b1})
            $display("FAIL down_wrap: got %h/%b/%b want 0008/0/1", if3.dcount, if3.overflow, if3.underflow);
        else passed++;
        tick();
        checks++;
        if ({if3.dcount, if3.underflow} !== {16'h0005, STICKY})
            $display("FAIL down_after_wrap: got %h/%b want 0005/%b", if3.dcount, if3.underflow, STICKY);
        else passed++;
    endtask

    task automatic test_priority();
        logic [15:0] held;
        rst = 1'b1; load_i = 1'b1; preld = 16'h1234; lim = 16'hFFFF;
        tick();
        checks++;
        if (if1.dcount !== 16'h0000)
            $display("FAIL reset_over_load: got %h want 0000", if1.dcount);
        else passed++;
        rst = 1'b0; lim = 16'h0010; preld = 16'h0020;
        tick();
        checks++;
        if (if1.dcount !== 16'h0010)
            $display("FAIL load_clamp: got %h want 0010", if1.dcount);
        else passed++;
        load_i = 1'b0; cin = 1'b0; updown = 1'b1;
        held = if1.dcount;
        for (int i = 0; i < 3; i++) begin
            updown = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if ({if1.dcount, if1.overflow, if1.underflow} !== {16'h0010, 1'b0, 1'b0})
                $display("FAIL hold%0d: got %h/%b/%b want 0010/0/0 (was %h)", i, if1.dcount, if1.overflow, if1.underflow, held);
            else passed++;
        end
        // _set wins over _load.
        lim = 16'h0030; preld = 16'h0003; set_i = 1'b1; load_i = 1'b1;
        tick();
        checks++;
        if (if1.dcount !== 16'h0030)
            $display("FAIL set_over_load: got %h want 0030", if1.dcount);
        else passed++;
        // Bound lowered below the count: up is a cross, out-of-range wrap gives 0.
        set_i = 1'b0; load_i = 1'b0; lim = 16'h0005; cin = 1'b1; updown = 1'b1; wrapstop = 1'b1;
        tick();
        checks++;
        if ({if1.dcount, if1.overflow, if1.underflow} !== {16'h0000, 1'b1, 1'b0})
            $display("FAIL lowered_up: got %h/%b/%b want 0000/1/0", if1.dcount, if1.overflow, if1.underflow);
        else passed++;
        // Bound lowered below the count: down is a plain subtract.
        lim = 16'h0030; set_i = 1'b1;
        tick();
        set_i = 1'b0; lim = 16'h0005; updown = 1'b0;
        tick();
        checks++;
        if ({if1.dcount, if1.overflow, if1.underflow} !== {16'h002F, 1'b0, 1'b0})
            $display("FAIL lowered_down: got %h/%b/%b want 002f/0/0", if1.dcount, if1.overflow, if1.underflow);
        else passed++;
        cin = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(0, 59) == 0);
            set_i  = ($urandom_range(0, 24) == 0);
            load_i = ($urandom_range(0, 11) == 0);
            preld  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: lim = 16'hFFFF;
                    1: lim = 16'($urandom_range(0, 3));
                    2: lim = 16'($urandom_range(0, 40));
                    default: lim = 16'($urandom);
                endcase
            end
            updown   = 1'($urandom_range(0, 1));
            wrapstop = 1'($urandom_range(0, 1));
            cin      = ($urandom_range(0, 9) < 8);
            #1;
            checks++;
            if ({if1.carry_out, if3.carry_out} !== {ref_carry(1, m1_cnt), ref_carry(3, m3_cnt)})
                $display("FAIL rnd_carry n=%0d: got %b%b want %b%b", n, if1.carry_out, if3.carry_out,
                         ref_carry(1, m1_cnt), ref_carry(3, m3_cnt));
            else passed++;
            tick();
            checks++;
            if ({if1.dcount, if1.overflow, if1.underflow} !== {m1_cnt, m1_ov, m1_un})
                $display("FAIL rnd_s1 n=%0d: got %h/%b/%b want %h/%b/%b", n, if1.dcount, if1.overflow, if1.underflow, m1_cnt, m1_ov, m1_un);
            else passed++;
            checks++;
            if ({if3.dcount, if3.overflow, if3.underflow} !== {m3_cnt, m3_ov, m3_un})
                $display("FAIL rnd_s3 n=%0d: got %h/%b/%b want %h/%b/%b", n, if3.dcount, if3.overflow, if3.underflow, m3_cnt, m3_ov, m3_un);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_up_down();
        test_wrap_overflow();
        test_stop_saturate();
        test_down_wrap();
        test_priority();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
